// File: rtl/wb_shared_bus.sv
// Shared Wishbone bus: round-robin arbitration across NM masters and address decode
// across NS slaves, with error responses for unmapped addresses and for strobe timeouts.
module wb_shared_bus #(
    parameter int NM = 2,
    parameter int NS = 3,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [NS*AW-1:0] SLAVE_BASE =
        {32'h9000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NS*AW-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_C000, 32'hFFFF_0000},
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM*3-1:0]      m_cti_i,
    input  logic [NM*2-1:0]      m_bte_i,
    output logic [NM*DW-1:0]     m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NM-1:0]        m_rty_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic [2:0]           s_cti_o,
    output logic [1:0]           s_bte_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i,
    input  logic [NS-1:0]        s_rty_i,
    output logic [NM-1:0]        grant_o
);

    localparam int SW  = DW / 8;
    localparam int IW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int SIW = (NS > 1) ? $clog2(NS) : 1;
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        DERR
    } state_t;

    state_t          state_q, state_d;
    logic [NM-1:0]   grant_q, grant_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rdy_q;

    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [SW-1:0]   own_sel;
    logic            own_we;
    logic            own_cyc;
    logic            own_stb;
    logic [2:0]      own_cti;
    logic [1:0]      own_bte;

    logic            sel_vld;
    logic [SIW-1:0]  sel_idx;
    logic            hit;
    logic            live;
    logic            pass;
    logic            rsp_ack;
    logic            rsp_err;
    logic            rsp_rty;
    logic [DW-1:0]   rsp_dat;

    logic            found;
    logic [IW-1:0]   pick;

    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_cti = '0;
        own_bte = '0;
        if (state_q != IDLE) begin
            own_adr = m_adr_i[int'(own_q)*AW +: AW];
            own_dat = m_dat_i[int'(own_q)*DW +: DW];
            own_sel = m_sel_i[int'(own_q)*SW +: SW];
            own_we  = m_we_i[own_q];
            own_cyc = m_cyc_i[own_q];
            own_stb = m_stb_i[own_q] & m_cyc_i[own_q];
            own_cti = m_cti_i[int'(own_q)*3 +: 3];
            own_bte = m_bte_i[int'(own_q)*2 +: 2];
        end
    end

    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;
    assign s_sel_o = own_sel;
    assign s_we_o  = own_we;
    assign s_cti_o = own_cti;
    assign s_bte_o = own_bte;
    assign grant_o = grant_q;

    // Descending scan so the lowest matching slave index wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if ((own_adr & SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                sel_vld = 1'b1;
                sel_idx = SIW'(k);
            end
        end
    end

    assign hit  = (TIMEOUT != 0) && (state_q == OWNED) &&
                  (cnt_q == CW'(TIMEOUT));
    assign live = (state_q == OWNED) && own_cyc;
    assign pass = live && sel_vld && !hit;

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        if (own_cyc && sel_vld) begin
            s_cyc_o[sel_idx] = 1'b1;
            s_stb_o[sel_idx] = live && own_stb && !hit;
        end
    end

    always_comb begin
        rsp_ack = 1'b0;
        rsp_err = 1'b0;
        rsp_rty = 1'b0;
        rsp_dat = '0;
        if (pass) begin
            rsp_ack = s_ack_i[sel_idx];
            rsp_err = s_err_i[sel_idx];
            rsp_rty = s_rty_i[sel_idx];
            rsp_dat = s_dat_i[int'(sel_idx)*DW +: DW];
        end
    end

    always_comb begin
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state_q != IDLE) begin
            m_dat_o[int'(own_q)*DW +: DW] = rsp_dat;
            m_ack_o[own_q] = rsp_ack;
            m_err_o[own_q] = rsp_err | (state_q == DERR);
            m_rty_o[own_q] = rsp_rty;
        end
    end

    // Round-robin search starting just after the previous owner.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NM; i++) begin
            if (!found && m_cyc_i[(int'(last_q) + 1 + i) % NM]) begin
                found = 1'b1;
                pick  = IW'((int'(last_q) + 1 + i) % NM);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        own_d   = own_q;
        last_d  = last_q;
        cnt_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (rdy_q && found) begin
                    state_d       = OWNED;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    own_d         = pick;
                    last_d        = pick;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (own_stb && (!sel_vld || hit)) begin
                    state_d = DERR;
                end else if (own_stb && (TIMEOUT != 0) &&
                             !(rsp_ack || rsp_err || rsp_rty)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DERR: begin
                state_d = OWNED;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            own_q   <= '0;
            last_q  <= IW'(NM - 1);
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            own_q   <= own_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus: arbitration, decode, error paths,
// bursts and asynchronous reset.
module tb_wb_shared_bus;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                wb_clk_i = 1'b0;
    logic                wb_rst_i = 1'b0;
    logic [NM*AW-1:0]    m_adr_i = '0;
    logic [NM*DW-1:0]    m_dat_i = '0;
    logic [NM*DW/8-1:0]  m_sel_i = '0;
    logic [NM-1:0]       m_we_i = '0;
    logic [NM-1:0]       m_cyc_i = '0;
    logic [NM-1:0]       m_stb_i = '0;
    logic [NM*3-1:0]     m_cti_i = '0;
    logic [NM*2-1:0]     m_bte_i = '0;
    logic [NM*DW-1:0]    m_dat_o;
    logic [NM-1:0]       m_ack_o;
    logic [NM-1:0]       m_err_o;
    logic [NM-1:0]       m_rty_o;
    logic [AW-1:0]       s_adr_o;
    logic [DW-1:0]       s_dat_o;
    logic [DW/8-1:0]     s_sel_o;
    logic                s_we_o;
    logic [2:0]          s_cti_o;
    logic [1:0]          s_bte_o;
    logic [NS-1:0]       s_cyc_o;
    logic [NS-1:0]       s_stb_o;
    logic [NS*DW-1:0]    s_dat_i = '0;
    logic [NS-1:0]       s_ack_i;
    logic [NS-1:0]       s_err_i = '0;
    logic [NS-1:0]       s_rty_i = '0;
    logic [NM-1:0]       grant_o;

    logic [NS-1:0]       s_ack_d = '0;
    logic                auto0 = 1'b0;

    int checks = 0;
    int failures = 0;

    assign s_ack_i = s_ack_d | {{(NS-1){1'b0}}, auto0 & s_stb_o[0]};

    wb_shared_bus #(
        .NM(NM), .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(4)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic set_m(input int i, input logic cyc,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc_i[i] = cyc;
        m_stb_i[i] = cyc;
        m_we_i[i] = 1'b0;
        m_adr_i[i*AW +: AW] = adr;
        m_cti_i[i*3 +: 3] = cti;
        m_dat_i[i*DW +: DW] = 32'hA5A5_0000 + i;
        m_sel_i[i*4 +: 4] = 4'hF;
        m_bte_i[i*2 +: 2] = 2'b00;
    endtask

    task automatic test_reset;
        set_m(0, 1'b1, 32'h0000_0000, 3'b000);
        tick;
        tick;
        checks++;
        if (grant_o !== 2'b00 || s_cyc_o !== 3'b000 || s_stb_o !== 3'b000) begin
            failures++;
            $display("FAIL rst_state: grant=%b cyc=%b stb=%b want 00/000/000",
                     grant_o, s_cyc_o, s_stb_o);
        end
        checks++;
        if (m_ack_o !== 2'b00 || m_err_o !== 2'b00 || m_rty_o !== 2'b00) begin
            failures++;
            $display("FAIL rst_resp: ack=%b err=%b rty=%b want 00",
                     m_ack_o, m_err_o, m_rty_o);
        end
        #3 wb_rst_i = 1'b1;
        tick;
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL rst_first_edge: grant=%b want 00", grant_o);
        end
        tick;
        checks++;
        if (grant_o !== 2'b01) begin
            failures++;
            $display("FAIL rst_second_edge: grant=%b want 01", grant_o);
        end
        set_m(0, 1'b0, 32'h0, 3'b000);
        tick;
        tick;
    endtask

    task automatic test_read;
        tick;
        set_m(0, 1'b1, 32'h1000_0004, 3'b000);
        #1;
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL read_arb_lat: grant=%b want 00", grant_o);
        end
        tick;
        checks++;
        if (grant_o !== 2'b01 || s_stb_o !== 3'b010 || s_cyc_o !== 3'b010) begin
            failures++;
            $display("FAIL read_select: grant=%b stb=%b cyc=%b want 01/010/010",
                     grant_o, s_stb_o, s_cyc_o);
        end
        checks++;
        if (s_adr_o !== 32'h1000_0004 || s_dat_o !== 32'hA5A5_0000 ||
            s_sel_o !== 4'hF || m_ack_o !== 2'b00) begin
            failures++;
            $display("FAIL read_fields: adr=%h dat=%h sel=%h ack=%b want 10000004/a5a50000/f/00",
                     s_adr_o, s_dat_o, s_sel_o, m_ack_o);
        end
        tick;
        tick;
        s_ack_d = 3'b010;
        s_dat_i[63:32] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (m_ack_o !== 2'b01 || m_dat_o[31:0] !== 32'hDEAD_BEEF ||
            m_dat_o[63:32] !== 32'h0) begin
            failures++;
            $display("FAIL read_ack: ack=%b dat=%h want 01/deadbeef/0",
                     m_ack_o, m_dat_o);
        end
        tick;
        s_ack_d = 3'b000;
        set_m(0, 1'b0, 32'h0, 3'b000);
        #1;
        checks++;
        if (s_cyc_o !== 3'b000 || grant_o !== 2'b01) begin
            failures++;
            $display("FAIL read_drop: cyc=%b grant=%b want 000/01",
                     s_cyc_o, grant_o);
        end
        tick;
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL read_release: grant=%b want 00", grant_o);
        end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g [0:10];
        logic [1:0] prev;
        int n0;
        int n1;
        exp_g = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01,
                  2'b00, 2'b10, 2'b10, 2'b00, 2'b01};
        prev = 2'b00;
        n0 = 0;
        n1 = 0;
        auto0 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            tick;
            set_m(0, !prev[0], 32'h0000_0010, 3'b000);
            set_m(1, !prev[1], 32'h0000_0020, 3'b000);
            #1;
            checks++;
            if (grant_o !== exp_g[c]) begin
                failures++;
                $display("FAIL alt_grant[%0d]: grant=%b want %b",
                         c, grant_o, exp_g[c]);
            end
            prev = m_ack_o;
            n0 += int'(m_ack_o[0]);
            n1 += int'(m_ack_o[1]);
        end
        checks++;
        if (n0 != 2 || n1 != 2) begin
            failures++;
            $display("FAIL alt_acks: m0=%0d m1=%0d want 2/2", n0, n1);
        end
        set_m(0, 1'b0, 32'h0, 3'b000);
        set_m(1, 1'b0, 32'h0, 3'b000);
        tick;
        tick;
        auto0 = 1'b0;
    endtask

    task automatic test_unmapped;
        tick;
        set_m(1, 1'b1, 32'h5000_0000, 3'b000);
        #1;
        tick;
        s_ack_d = 3'b001;
        #1;
        checks++;
        if (grant_o !== 2'b10 || s_stb_o !== 3'b000 || s_cyc_o !== 3'b000 ||
            m_err_o !== 2'b00 || m_ack_o !== 2'b00) begin
            failures++;
            $display("FAIL unmap_owned: grant=%b stb=%b cyc=%b err=%b ack=%b want 10/000/000/00/00",
                     grant_o, s_stb_o, s_cyc_o, m_err_o, m_ack_o);
        end
        tick;
        s_ack_d = 3'b000;
        #1;
        checks++;
        if (m_err_o !== 2'b10 || s_stb_o !== 3'b000) begin
            failures++;
            $display("FAIL unmap_err: err=%b stb=%b want 10/000",
                     m_err_o, s_stb_o);
        end
        tick;
        set_m(1, 1'b0, 32'h0, 3'b000);
        #1;
        checks++;
        if (m_err_o !== 2'b00) begin
            failures++;
            $display("FAIL unmap_err_once: err=%b want 00", m_err_o);
        end
        tick;
        tick;
    endtask

    task automatic test_timeout;
        tick;
        set_m(0, 1'b1, 32'h9000_0010, 3'b000);
        #1;
        for (int b = 1; b <= 4; b++) begin
            tick;
            checks++;
            if (s_stb_o !== 3'b100 || grant_o !== 2'b01 || m_err_o !== 2'b00) begin
                failures++;
                $display("FAIL tmo_strobe[%0d]: stb=%b grant=%b err=%b want 100/01/00",
                         b, s_stb_o, grant_o, m_err_o);
            end
        end
        tick;
        checks++;
        if (s_stb_o !== 3'b000 || m_err_o !== 2'b00) begin
            failures++;
            $display("FAIL tmo_hit: stb=%b err=%b want 000/00", s_stb_o, m_err_o);
        end
        tick;
        checks++;
        if (m_err_o !== 2'b01 || s_stb_o !== 3'b000 || grant_o !== 2'b01) begin
            failures++;
            $display("FAIL tmo_err: err=%b stb=%b grant=%b want 01/000/01",
                     m_err_o, s_stb_o, grant_o);
        end
        tick;
        checks++;
        if (m_err_o !== 2'b00 || grant_o !== 2'b01 || s_stb_o !== 3'b100) begin
            failures++;
            $display("FAIL tmo_retain: err=%b grant=%b stb=%b want 00/01/100",
                     m_err_o, grant_o, s_stb_o);
        end
        tick;
        set_m(0, 1'b0, 32'h0, 3'b000);
        tick;
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL tmo_release: grant=%b want 00", grant_o);
        end
    endtask

    task automatic test_back_to_back;
        tick;
        set_m(0, 1'b1, 32'h0000_0100, 3'b010);
        #1;
        tick;
        set_m(1, 1'b1, 32'h0000_0200, 3'b000);
        s_ack_d = 3'b001;
        #1;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                tick;
                set_m(0, 1'b1, 32'h0000_0100 + 32'(4*b),
                      (b == 3) ? 3'b111 : 3'b010);
                #1;
            end
            checks++;
            if (m_ack_o !== 2'b01 || grant_o !== 2'b01 ||
                s_adr_o !== 32'h0000_0100 + 32'(4*b) ||
                s_cti_o !== ((b == 3) ? 3'b111 : 3'b010)) begin
                failures++;
                $display("FAIL burst_beat[%0d]: ack=%b grant=%b adr=%h cti=%b",
                         b, m_ack_o, grant_o, s_adr_o, s_cti_o);
            end
        end
        tick;
        s_ack_d = 3'b000;
        set_m(0, 1'b0, 32'h0, 3'b000);
        #1;
        checks++;
        if (grant_o !== 2'b01 || m_ack_o !== 2'b00) begin
            failures++;
            $display("FAIL burst_drop: grant=%b ack=%b want 01/00", grant_o, m_ack_o);
        end
        tick;
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL burst_dead: grant=%b want 00", grant_o);
        end
        tick;
        checks++;
        if (grant_o !== 2'b10) begin
            failures++;
            $display("FAIL burst_next: grant=%b want 10", grant_o);
        end
        set_m(1, 1'b0, 32'h0, 3'b000);
        tick;
        tick;
    endtask

    task automatic test_reset_mid;
        tick;
        set_m(0, 1'b1, 32'h0000_0300, 3'b010);
        #1;
        tick;
        s_ack_d = 3'b001;
        tick;
        set_m(0, 1'b1, 32'h0000_0304, 3'b010);
        tick;
        set_m(0, 1'b1, 32'h0000_0308, 3'b010);
        #1;
        checks++;
        if (m_ack_o !== 2'b01 || s_stb_o !== 3'b001) begin
            failures++;
            $display("FAIL rmid_beat3: ack=%b stb=%b want 01/001", m_ack_o, s_stb_o);
        end
        #2 wb_rst_i = 1'b0;
        #1;
        checks++;
        if (grant_o !== 2'b00 || s_stb_o !== 3'b000 || s_cyc_o !== 3'b000 ||
            m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
            failures++;
            $display("FAIL rmid_zero: grant=%b stb=%b cyc=%b ack=%b err=%b want all 0",
                     grant_o, s_stb_o, s_cyc_o, m_ack_o, m_err_o);
        end
        s_ack_d = 3'b000;
        set_m(0, 1'b0, 32'h0, 3'b000);
        set_m(1, 1'b1, 32'h1000_0000, 3'b000);
        #1 wb_rst_i = 1'b1;
        tick;
        checks++;
        if (grant_o !== 2'b00) begin
            failures++;
            $display("FAIL rmid_first_edge: grant=%b want 00", grant_o);
        end
        tick;
        checks++;
        if (grant_o !== 2'b10 || s_stb_o !== 3'b010) begin
            failures++;
            $display("FAIL rmid_m1_grant: grant=%b stb=%b want 10/010",
                     grant_o, s_stb_o);
        end
        set_m(1, 1'b0, 32'h0, 3'b000);
        tick;
        tick;
    endtask

    initial begin
        test_reset;
        test_read;
        test_alternate;
        test_unmapped;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_shared_bus.md
WB_SHARED_BUS -- requirements
Module: wb_shared_bus

Interface
REQ-001 Parameter NM, default 2, number of Wishbone masters (1..8).
REQ-002 Parameter NS, default 3, number of Wishbone slaves (1..8).
REQ-003 Parameter AW, default 32, address width; DW, default 32, data width (multiple of 8).
REQ-004 Parameter SLAVE_BASE, default {32'h9000_0000, 32'h1000_0000, 32'h0000_0000}, NS*AW packed base addresses, slave 0 in LSBs.
REQ-005 Parameter SLAVE_MASK, default {32'hFFFF_F000, 32'hFFFF_C000, 32'hFFFF_0000}, NS*AW packed decode masks.
REQ-006 Parameter TIMEOUT, default 255, cycles of unanswered strobe before a bus error; 0 disables the timeout.
REQ-007 One clock; reset is asynchronous and active-low: wb_clk_i input 1, clock; wb_rst_i input 1, asynchronous active-low reset.
REQ-008 m_adr_i input NM*AW; m_dat_i input NM*DW; m_sel_i input NM*DW/8; m_we_i, m_cyc_i, m_stb_i input NM each; m_cti_i input NM*3; m_bte_i input NM*2: per-master request fields.
REQ-009 m_dat_o output NM*DW; m_ack_o, m_err_o, m_rty_o output NM each: per-master responses.
REQ-010 s_adr_o output AW; s_dat_o output DW; s_sel_o output DW/8; s_we_o output 1; s_cti_o output 3; s_bte_o output 2: shared slave-side request fields.
REQ-011 s_cyc_o, s_stb_o output NS each: per-slave select; s_dat_i input NS*DW; s_ack_i, s_err_i, s_rty_i input NS each.
REQ-012 grant_o output NM: one-hot current bus owner, zero when idle.

Function
REQ-013 The FSM SHALL have states IDLE, OWNED and DERR.
REQ-014 In IDLE, with any m_cyc_i high, the block SHALL register a grant next cycle to the first requesting master, searched round-robin from (last owner + 1) mod NM; one-cycle arbitration latency; go to OWNED.
REQ-015 In OWNED, grant SHALL hold until the owner drops m_cyc_i; that cycle forces s_cyc_o/s_stb_o to zero and returns to IDLE; no other master is granted in the same cycle (one dead cycle minimum between owners).
REQ-016 Shared request fields SHALL equal the owner's fields, combinationally; all zero when no owner.
REQ-017 Decode: target slave is the lowest index k with (owner adr & MASK[k]) == BASE[k]; s_cyc_o[k] = owner cyc, s_stb_o[k] = owner stb; all other bits zero.
REQ-018 Owner's m_dat_o/m_ack_o/m_err_o/m_rty_o SHALL equal the target slave's response combinationally (zero added latency); non-owner responses SHALL be zero.
REQ-019 Unmapped address with owner stb high: no slave selected; FSM enters DERR next cycle, asserts owner m_err_o for exactly one cycle, then returns to OWNED.
REQ-020 Timeout counter (width clog2(TIMEOUT+1)) SHALL clear on any ack/err/rty to the owner, on owner stb low, and in IDLE; increment while owner stb high and unanswered.
REQ-021 On counter reaching TIMEOUT: go to DERR, drop s_stb_o that cycle and the next, one-cycle m_err_o to owner, counter cleared.
REQ-022 In DERR, s_stb_o SHALL be zero and slave responses SHALL NOT reach the master.
REQ-023 Slave response asserted while that slave is not selected SHALL be ignored.
REQ-024 Owner stb held across several acks (burst/pipelined) SHALL be passed through unchanged; grant is not released between beats.
REQ-025 NM=1 SHALL still use the one-cycle grant latency.

Reset
REQ-026 wb_rst_i low SHALL asynchronously force state IDLE, grant_o=0, all s_cyc_o/s_stb_o=0, all m_ack_o/m_err_o/m_rty_o=0, timeout counter 0, round-robin pointer so master 0 is searched first.
REQ-027 Reset mid-transfer SHALL drop all strobes immediately; no pending error pulse survives reset.
REQ-028 Release of reset SHALL be synchronised by the caller; the block takes first grant on the second rising edge after release at earliest.

Verification
REQ-029 Master 0 read 0x1000_0004, slave 1 acks after 2 cycles with 0xDEADBEEF -> grant_o=01 one cycle after cyc, s_stb_o=010, m_ack_o[0] with m_dat_o=0xDEADBEEF.
REQ-030 Masters 0 and 1 request continuously, each 1-beat cycle -> grants alternate 01,10,01,... with one idle cycle between owners.
REQ-031 Master 1 accesses 0x5000_0000 -> s_stb_o=000, m_err_o[1] one cycle, no slave response.
REQ-032 TIMEOUT=4, slave 2 never answers -> m_err_o after 4 strobe cycles, s_stb_o low, grant retained until cyc drops.
REQ-033 Reset asserted during slave-0 burst beat 3 -> all outputs zero same cycle; after release master 1 requesting alone is granted.
REQ-034 Master 0 4-beat burst (cti=010) to slave 0 while master 1 requests -> master 1 granted only after master 0 drops cyc.
